// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: FSM states, RCON table, S-box function.
// Used by aes_key_expand_ctrl (optional zeroize via KEYSCHED_ZEROIZE_EN) and aes_key_round_step.
package aes_pkg;

  localparam int KEY_W   = 128;
  localparam int NUM_RND = 10;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ks_state_e;

  localparam logic [7:0] RCON [NUM_RND] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Rounds outside 1..NUM_RND contribute no round constant.
  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    logic [7:0] rc;
    rc = 8'h00;
    for (int i = 0; i < NUM_RND; i++) begin
      if (rnd == 4'(i + 1)) rc = RCON[i];
    end
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// Combinational AES-128 key-schedule round: previous round key + round number -> next round key.
module aes_key_round_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  logic [3:0]       rnd_i,
  output logic [KEY_W-1:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub[8*b +: 8] = sbox(rot[8*b +: 8]);
  end

  assign n0 = w0 ^ sub ^ {rcon_of(rnd_i), 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key expansion controller: one schedule round per clock into an 11-entry round-key file.
// Define KEYSCHED_ZEROIZE_EN to add the zeroize input that wipes all key material.
module aes_key_expand_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic [KEY_W-1:0] ip_key,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             busy,
  output logic             keys_valid,
  input  logic [3:0]       rd_idx,
  input  logic             rd_en,
  output logic [KEY_W-1:0] op_key,
  output logic             rd_valid
);

  localparam int NUM_KEYS = NUM_RND + 1;

  ks_state_e        state_q, state_d;
  logic [3:0]       rnd_cnt_q, rnd_cnt_d;
  logic [KEY_W-1:0] work_key_q;
  logic [KEY_W-1:0] next_key;
  logic [KEY_W-1:0] rf_q [NUM_KEYS];
  logic [KEY_W-1:0] op_key_q, op_key_d;
  logic [KEY_W-1:0] rd_data;
  logic             rd_valid_q, rd_valid_d;
  logic             zero_req;
  logic             rf_we;
  logic [3:0]       rf_widx;
  logic [KEY_W-1:0] rf_wdata;

`ifdef KEYSCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  aes_key_round_step u_round_step (
    .key_i (work_key_q),
    .rnd_i (rnd_cnt_q),
    .key_o (next_key)
  );

  // Whatever is written to the register file also becomes the working key.
  always_comb begin
    state_d   = state_q;
    rnd_cnt_d = rnd_cnt_q;
    key_ready = 1'b0;
    rf_we     = 1'b0;
    rf_widx   = rnd_cnt_q;
    rf_wdata  = next_key;
    unique case (state_q)
      IDLE, DONE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          state_d   = EXPAND;
          rnd_cnt_d = 4'd1;
          rf_we     = 1'b1;
          rf_widx   = 4'd0;
          rf_wdata  = ip_key;
        end
      end
      EXPAND: begin
        rf_we = 1'b1;
        if (rnd_cnt_q == 4'(NUM_RND)) begin
          state_d = DONE;
        end else begin
          rnd_cnt_d = rnd_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (zero_req) begin
      state_d   = IDLE;
      rnd_cnt_d = 4'd0;
      rf_we     = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rd_idx == 4'(i)) rd_data = rf_q[i];
    end
    op_key_d   = op_key_q;
    rd_valid_d = 1'b0;
    if (rd_en) begin
      op_key_d   = rd_data;
      rd_valid_d = 1'b1;
    end
    if (zero_req) begin
      op_key_d   = '0;
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rnd_cnt_q  <= 4'd0;
      op_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnd_cnt_q  <= rnd_cnt_d;
      op_key_q   <= op_key_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Key storage is deliberately not reset; only zeroize wipes it.
  always_ff @(posedge clk) begin
    if (zero_req) begin
      work_key_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      work_key_q <= rf_wdata;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (rf_widx == 4'(i)) rf_q[i] <= rf_wdata;
      end
    end
  end

  assign busy       = (state_q == EXPAND);
  assign keys_valid = (state_q == DONE);
  assign op_key     = op_key_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Directed testbench for aes_key_expand_ctrl using FIPS-197 and all-zero key schedules.
// The zeroize scenario is built only when KEYSCHED_ZEROIZE_EN is defined.
module tb_aes_key_expand_ctrl;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_KEY  = 128'h0;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         rst_n;
  logic [127:0] ip_key;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic         rd_en;
  logic [127:0] op_key;
  logic         rd_valid;
`ifdef KEYSCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  int checks   = 0;
  int failures = 0;

  aes_key_expand_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef KEYSCHED_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .ip_key     (ip_key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_en      (rd_en),
    .op_key     (op_key),
    .rd_valid   (rd_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not terminate");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_key(input logic [127:0] k);
    ip_key    = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic read_key(input logic [3:0] idx, output logic [127:0] data, output logic vld);
    rd_idx = idx;
    rd_en  = 1'b1;
    step();
    data  = op_key;
    vld   = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (keys_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ip_key = '0; key_valid = 1'b0; rd_idx = '0; rd_en = 1'b0;
`ifdef KEYSCHED_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    repeat (2) step();
    checks++;
    if ({key_ready, busy, keys_valid, rd_valid} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=1000", {key_ready, busy, keys_valid, rd_valid});
    end
    checks++;
    if (op_key !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_op_key got=%h exp=0", op_key);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fips_key();
    int n, bc;
    logic [127:0] d;
    logic v;
    offer_key(FIPS_KEY);
    checks++;
    if ({key_ready, busy, keys_valid} !== 3'b010) begin
      failures++;
      $display("[TB] FAIL accept_flags got=%b exp=010", {key_ready, busy, keys_valid});
    end
    n = 0; bc = 0;
    while (keys_valid !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bc++;
      step();
      n++;
    end
    checks++;
    if (n != 10) begin
      failures++;
      $display("[TB] FAIL done_latency got=%0d exp=10", n);
    end
    checks++;
    if (bc != 10) begin
      failures++;
      $display("[TB] FAIL busy_cycles got=%0d exp=10", bc);
    end
    checks++;
    if ({key_ready, busy} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL done_flags got=%b exp=10", {key_ready, busy});
    end
    read_key(4'd1, d, v);
    checks++;
    if (d !== FIPS_RK1 || v !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fips_rk1 got=%h/%b exp=%h/1", d, v, FIPS_RK1);
    end
    read_key(4'd2, d, v);
    checks++;
    if (d !== FIPS_RK2) begin
      failures++;
      $display("[TB] FAIL fips_rk2 got=%h exp=%h", d, FIPS_RK2);
    end
    read_key(4'd10, d, v);
    checks++;
    if (d !== FIPS_RK10) begin
      failures++;
      $display("[TB] FAIL fips_rk10 got=%h exp=%h", d, FIPS_RK10);
    end
    read_key(4'd0, d, v);
    checks++;
    if (d !== FIPS_KEY) begin
      failures++;
      $display("[TB] FAIL fips_rk0 got=%h exp=%h", d, FIPS_KEY);
    end
  endtask

  task automatic test_read_range();
    logic [127:0] d;
    logic v;
    read_key(4'd11, d, v);
    checks++;
    if (d !== 128'h0 || v !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rd_idx11 got=%h/%b exp=0/1", d, v);
    end
    read_key(4'd2, d, v);
    read_key(4'd15, d, v);
    checks++;
    if (d !== 128'h0 || v !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rd_idx15 got=%h/%b exp=0/1", d, v);
    end
    read_key(4'd2, d, v);
    rd_idx = 4'd10;
    step();
    checks++;
    if (rd_valid !== 1'b0 || op_key !== FIPS_RK2) begin
      failures++;
      $display("[TB] FAIL rd_hold got=%h/%b exp=%h/0", op_key, rd_valid, FIPS_RK2);
    end
  endtask

  task automatic test_zero_key();
    int n;
    logic [127:0] d;
    logic v;
    offer_key(ZERO_KEY);
    wait_done(n);
    checks++;
    if (n != 10) begin
      failures++;
      $display("[TB] FAIL zero_latency got=%0d exp=10", n);
    end
    read_key(4'd1, d, v);
    checks++;
    if (d !== ZERO_RK1) begin
      failures++;
      $display("[TB] FAIL zero_rk1 got=%h exp=%h", d, ZERO_RK1);
    end
    read_key(4'd2, d, v);
    checks++;
    if (d !== ZERO_RK2) begin
      failures++;
      $display("[TB] FAIL zero_rk2 got=%h exp=%h", d, ZERO_RK2);
    end
    read_key(4'd10, d, v);
    checks++;
    if (d !== ZERO_RK10) begin
      failures++;
      $display("[TB] FAIL zero_rk10 got=%h exp=%h", d, ZERO_RK10);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    logic [127:0] d;
    logic v;
    offer_key(FIPS_KEY);
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      ip_key    = ZERO_KEY;
      key_valid = 1'b1;
      step();
      if (key_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    key_valid = 1'b0;
    step();
    checks++;
    if (bad != 0 || keys_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL expand_ignore bad_cycles=%0d keys_valid=%b exp=0/1", bad, keys_valid);
    end
    read_key(4'd1, d, v);
    checks++;
    if (d !== FIPS_RK1) begin
      failures++;
      $display("[TB] FAIL b2b_rk1 got=%h exp=%h", d, FIPS_RK1);
    end
    read_key(4'd10, d, v);
    checks++;
    if (d !== FIPS_RK10) begin
      failures++;
      $display("[TB] FAIL b2b_rk10 got=%h exp=%h", d, FIPS_RK10);
    end
    offer_key(ZERO_KEY);
    checks++;
    if ({keys_valid, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL restart_flags got=%b exp=01", {keys_valid, busy});
    end
    wait_done(bad);
    read_key(4'd1, d, v);
    checks++;
    if (d !== ZERO_RK1) begin
      failures++;
      $display("[TB] FAIL restart_rk1 got=%h exp=%h", d, ZERO_RK1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [127:0] d;
    logic v;
    offer_key(FIPS_KEY);
    repeat (3) step();
    read_key(4'd10, d, v);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_ready, busy, keys_valid, rd_valid} !== 4'b1000 || op_key !== 128'h0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b/%h exp=1000/0", {key_ready, busy, keys_valid, rd_valid}, op_key);
    end
    step();
    rst_n = 1'b1;
    step();
    offer_key(FIPS_KEY);
    wait_done(n);
    checks++;
    if (n != 10) begin
      failures++;
      $display("[TB] FAIL post_reset_latency got=%0d exp=10", n);
    end
    read_key(4'd1, d, v);
    checks++;
    if (d !== FIPS_RK1) begin
      failures++;
      $display("[TB] FAIL post_reset_rk1 got=%h exp=%h", d, FIPS_RK1);
    end
    read_key(4'd10, d, v);
    checks++;
    if (d !== FIPS_RK10) begin
      failures++;
      $display("[TB] FAIL post_reset_rk10 got=%h exp=%h", d, FIPS_RK10);
    end
  endtask

`ifdef KEYSCHED_ZEROIZE_EN
  task automatic test_zeroize();
    int seen;
    logic [127:0] d;
    logic v;
    offer_key(FIPS_KEY);
    repeat (2) step();
    zeroize   = 1'b1;
    key_valid = 1'b1;
    ip_key    = ZERO_KEY;
    rd_en     = 1'b1;
    rd_idx    = 4'd0;
    step();
    zeroize = 1'b0; key_valid = 1'b0; rd_en = 1'b0;
    checks++;
    if ({key_ready, busy, keys_valid, rd_valid} !== 4'b1000 || op_key !== 128'h0) begin
      failures++;
      $display("[TB] FAIL zeroize_state got=%b/%h exp=1000/0", {key_ready, busy, keys_valid, rd_valid}, op_key);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (keys_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("[TB] FAIL zeroize_no_accept got=%0d exp=0", seen);
    end
    read_key(4'd0, d, v);
    checks++;
    if (d !== 128'h0 || v !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zeroize_rk0 got=%h/%b exp=0/1", d, v);
    end
    read_key(4'd1, d, v);
    checks++;
    if (d !== 128'h0) begin
      failures++;
      $display("[TB] FAIL zeroize_rk1 got=%h exp=0", d);
    end
    read_key(4'd10, d, v);
    checks++;
    if (d !== 128'h0) begin
      failures++;
      $display("[TB] FAIL zeroize_rk10 got=%h exp=0", d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fips_key();
    test_read_range();
    test_zero_key();
    test_back_to_back();
    test_reset_mid();
`ifdef KEYSCHED_ZEROIZE_EN
    test_zeroize();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
